alu_dm_ext_unit: RTL and testbench

- Execute/memory slice of the single-cycle MIPS datapath.
- Combines three parts: the immediate extender (EXT), the B-operand select feeding a 2-bit-op ALU, and a word-addressed data memory (DM).
- The data memory is addressed by ALU result bits [11:2].
- Sits between the register file/control unit and the write-back select mux.

---
 rtl/alu_dm_ext_unit_pkg.sv | 17 +
 rtl/alu_dm_ext_mem.sv | 41 ++++
 rtl/alu_dm_ext_unit.sv | 77 +++++++
 tb/tb_alu_dm_ext_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_dm_ext_unit_pkg.sv
// Shared definitions for the execute/memory slice of the single-cycle MIPS
// datapath: the datapath width plus the ALU and immediate-extension opcodes.
package alu_dm_ext_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;
    localparam logic [1:0] ALUOP_SLT = 2'b11;

    // Opcode 2'b11 also zero-extends.
    localparam logic [1:0] EXTOP_ZERO = 2'b00;
    localparam logic [1:0] EXTOP_SIGN = 2'b01;
    localparam logic [1:0] EXTOP_LUI  = 2'b10;

endpackage

// File: rtl/alu_dm_ext_mem.sv
// Word-organised data memory: asynchronous read, synchronous write and an
// asynchronous reset that clears every word.
// Ports:
//   clk   - write clock (rising edge)
//   rst   - asynchronous active-high clear; blocks writes while high
//   we    - write enable
//   addr  - word address (DM_AW bits)
//   wdata - store data
//   rdata - combinational read of mem[addr]
module alu_dm_ext_mem
    import alu_dm_ext_unit_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DM_AW-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** DM_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clearing the whole array on reset is what makes reset visible on
    // rdata immediately, so the storage cannot be mapped to a plain RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/alu_dm_ext_unit.sv
// Execute/memory slice of the single-cycle MIPS datapath: immediate
// extender, ALU B-operand select, 2-bit-op ALU and word-addressed data memory.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset (clears memory)
//   aluop_i     - ALU operation (add, sub, or, signed set-less-than)
//   extop_i     - immediate extension (zero, sign, load-upper)
//   bsel_i      - ALU B operand: 0 = rd1_i, 1 = imm32_o
//   dmwr_i      - data-memory write enable
//   imm16_i     - instruction immediate
//   rd0_i/rd1_i - register-file read ports (A operand / B candidate, store data)
//   imm32_o     - extended immediate
//   aluout_o    - ALU result, also the data-memory byte address
//   zero_o      - high when aluout_o is zero
//   dm_rdata_o  - data-memory read data
module alu_dm_ext_unit
    import alu_dm_ext_unit_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        aluop_i,
    input  logic [1:0]        extop_i,
    input  logic              bsel_i,
    input  logic              dmwr_i,
    input  logic [15:0]       imm16_i,
    input  logic [DATA_W-1:0] rd0_i,
    input  logic [DATA_W-1:0] rd1_i,
    output logic [DATA_W-1:0] imm32_o,
    output logic [DATA_W-1:0] aluout_o,
    output logic              zero_o,
    output logic [DATA_W-1:0] dm_rdata_o
);

    function automatic logic [DATA_W-1:0] ext_imm(input logic [1:0] op,
                                                  input logic [15:0] imm);
        case (op)
            EXTOP_SIGN: ext_imm = {{16{imm[15]}}, imm};
            EXTOP_LUI:  ext_imm = {imm, 16'h0000};
            default:    ext_imm = {16'h0000, imm};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_calc(input logic [1:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
        case (op)
            ALUOP_ADD: alu_calc = a + b;
            ALUOP_SUB: alu_calc = a - b;
            ALUOP_OR:  alu_calc = a | b;
            default:   alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
        endcase
    endfunction

    logic signed [DATA_W-1:0] alu_a;
    logic signed [DATA_W-1:0] alu_b;

    assign imm32_o  = ext_imm(extop_i, imm16_i);
    assign alu_a    = rd0_i;
    assign alu_b    = bsel_i ? imm32_o : rd1_i;
    assign aluout_o = alu_calc(aluop_i, alu_a, alu_b);
    assign zero_o   = (aluout_o == '0);

    // Byte offset [1:0] dropped; bits above the word index are ignored, so
    // addresses wrap modulo the memory depth. Store data is always rd1_i.
    alu_dm_ext_mem #(
        .DM_AW (DM_AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (dmwr_i),
        .addr  (aluout_o[DM_AW+1:2]),
        .wdata (rd1_i),
        .rdata (dm_rdata_o)
    );

endmodule

// File: tb/tb_alu_dm_ext_unit.sv
module tb_alu_dm_ext_unit;

    localparam int DM_AW = 10;
    localparam int DEPTH = 2 ** DM_AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  aluop_i = 2'b00;
    logic [1:0]  extop_i = 2'b00;
    logic        bsel_i = 1'b0;
    logic        dmwr_i = 1'b0;
    logic [15:0] imm16_i = 16'h0;
    logic [31:0] rd0_i = 32'h0;
    logic [31:0] rd1_i = 32'h0;
    logic [31:0] imm32_o;
    logic [31:0] aluout_o;
    logic        zero_o;
    logic [31:0] dm_rdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];

    alu_dm_ext_unit #(.DM_AW(DM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .extop_i    (extop_i),
        .bsel_i     (bsel_i),
        .dmwr_i     (dmwr_i),
        .imm16_i    (imm16_i),
        .rd0_i      (rd0_i),
        .rd1_i      (rd1_i),
        .imm32_o    (imm32_o),
        .aluout_o   (aluout_o),
        .zero_o     (zero_o),
        .dm_rdata_o (dm_rdata_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model, written directly from the arithmetic rules.
    function automatic logic [31:0] m_imm(input logic [1:0] op, input logic [15:0] imm);
        longint unsigned v;
        v = imm;
        if (op == 2'b01 && imm >= 16'h8000) v = 64'hFFFF0000 + v;
        if (op == 2'b10) v = v * 65536;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub, r;
        ua = a; ub = b;
        sa = (a >= 32'h80000000) ? longint'(ua) - 64'sh100000000 : longint'(ua);
        sb = (b >= 32'h80000000) ? longint'(ub) - 64'sh100000000 : longint'(ub);
        case (op)
            2'b00:   r = (ua + ub) % 64'h100000000;
            2'b01:   r = (ua + 64'h100000000 - ub) % 64'h100000000;
            2'b10:   r = ua | ub;
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return r[31:0];
    endfunction

    function automatic int m_addr(input logic [31:0] byte_addr);
        return int'((byte_addr / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] m_out();
        return m_alu(aluop_i, rd0_i, bsel_i ? m_imm(extop_i, imm16_i) : rd1_i);
    endfunction

    // Drive one operation at the falling edge and check every output.
    task automatic apply(input logic [1:0] aop, input logic [1:0] eop, input logic bs,
                         input logic wr, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        @(negedge clk);
        aluop_i = aop; extop_i = eop; bsel_i = bs; dmwr_i = wr;
        imm16_i = imm; rd0_i = a; rd1_i = b;
        #1;
        e = m_out();
        chk("imm32", imm32_o, m_imm(eop, imm));
        chk("aluout", aluout_o, e);
        chk("zero", {31'b0, zero_o}, {31'b0, e == 32'h0});
        chk("rdata", dm_rdata_o, rst ? 32'h0 : model_mem[m_addr(e)]);
    endtask

    // Advance through a rising edge, updating the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst && dmwr_i) model_mem[m_addr(m_out())] = rd1_i;
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        // Reset state
        #2;
        chk("rst_rdata0", dm_rdata_o, 32'h0);
        rd0_i = 32'h20; #1;
        chk("rst_rdata8", dm_rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // EXT
        apply(2'b00, 2'b00, 1'b0, 1'b0, 16'h8001, 32'h0, 32'h0);
        chk("ext00", imm32_o, 32'h00008001);
        apply(2'b00, 2'b01, 1'b0, 1'b0, 16'h8001, 32'h0, 32'h0);
        chk("ext01", imm32_o, 32'hFFFF8001);
        apply(2'b00, 2'b10, 1'b0, 1'b0, 16'h8001, 32'h0, 32'h0);
        chk("ext10", imm32_o, 32'h80010000);
        apply(2'b00, 2'b11, 1'b0, 1'b0, 16'h8001, 32'h0, 32'h0);
        chk("ext11", imm32_o, 32'h00008001);

        // ALU, register operand
        apply(2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 32'h7FFFFFFF, 32'h1);
        chk("add_ovf", aluout_o, 32'h80000000);
        chk("add_zero", {31'b0, zero_o}, 32'h0);
        apply(2'b01, 2'b00, 1'b0, 1'b0, 16'h0, 32'h1234, 32'h1234);
        chk("sub_eq", aluout_o, 32'h0);
        chk("sub_zero", {31'b0, zero_o}, 32'h1);
        apply(2'b10, 2'b00, 1'b0, 1'b0, 16'h0, 32'hF0, 32'h0F);
        chk("or", aluout_o, 32'hFF);
        apply(2'b11, 2'b00, 1'b0, 1'b0, 16'h0, 32'hFFFFFFFF, 32'h1);
        chk("slt_neg", aluout_o, 32'h1);
        apply(2'b11, 2'b00, 1'b0, 1'b0, 16'h0, 32'h1, 32'hFFFFFFFF);
        chk("slt_swap", aluout_o, 32'h0);
        chk("slt_zero", {31'b0, zero_o}, 32'h1);

        // Immediate path
        apply(2'b00, 2'b01, 1'b1, 1'b0, 16'hFFFC, 32'h100, 32'h0);
        chk("imm_add", aluout_o, 32'hFC);

        // Store / load, aliasing and wrap
        apply(2'b00, 2'b00, 1'b1, 1'b1, 16'h4, 32'h10, 32'hDEADBEEF);
        tick();
        apply(2'b00, 2'b00, 1'b1, 1'b0, 16'h4, 32'h10, 32'h0);
        chk("load5", dm_rdata_o, 32'hDEADBEEF);
        apply(2'b00, 2'b00, 1'b1, 1'b0, 16'h4, 32'h13, 32'h0);
        chk("load17", dm_rdata_o, 32'hDEADBEEF);
        apply(2'b00, 2'b00, 1'b1, 1'b0, 16'h4, 32'h1010, 32'h0);
        chk("load1014", dm_rdata_o, 32'hDEADBEEF);

        // Mid-cycle reset beats a concurrent write
        apply(2'b00, 2'b00, 1'b1, 1'b1, 16'h4, 32'h10, 32'hCAFEF00D);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        #1;
        chk("rst_async", dm_rdata_o, 32'h0);
        tick();
        chk("rst_hold", dm_rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel", dm_rdata_o, 32'h0);
        tick();
        chk("post_rst_wr", dm_rdata_o, 32'hCAFEF00D);

        // Read during write
        apply(2'b00, 2'b00, 1'b1, 1'b1, 16'h4, 32'h10, 32'h11111111);
        tick();
        apply(2'b00, 2'b00, 1'b1, 1'b1, 16'h4, 32'h10, 32'h22222222);
        chk("rdw_old", dm_rdata_o, 32'h11111111);
        tick();
        chk("rdw_new", dm_rdata_o, 32'h22222222);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            apply(2'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 64)),
                  a, $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
